// File: rtl/bf16_mul_pipe.sv
// rtl/bf16_mul_pipe.sv - three-stage bf16 multiplier with valid/ready and sideband tag
// Optional round-to-nearest-even in the pack stage when BF16_MUL_RNE_EN is defined.
module bf16_mul_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_prod,
  output logic [TAG_W-1:0] out_tag
);

  logic adv1, adv2, adv3;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  logic             s1_sign_q, s1_aspec_q, s1_bspec_q, s1_zero_q;
  logic [7:0]       s1_ea_q, s1_eb_q, s1_ma_q, s1_mb_q;
  logic [15:0]      s1_a_q, s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_aspec_d, s1_bspec_d, s1_zero_d;

  logic                s2_sign_q, s2_aspec_q, s2_bspec_q, s2_zero_q;
  logic [15:0]         s2_p_q, s2_a_q, s2_b_q;
  logic signed [9:0]   s2_esum_q;
  logic [TAG_W-1:0]    s2_tag_q;
  logic [15:0]         s2_p_d;
  logic signed [9:0]   s2_esum_d;

  logic [15:0]       s3_prod_q, s3_prod_d;
  logic [TAG_W-1:0]  s3_tag_q;
  logic [6:0]        frac;
  logic signed [9:0] e;

  // Bubbles collapse: a stage may load whenever it is empty or its successor moves.
  assign adv3     = !s3_valid_q || out_ready;
  assign adv2     = !s2_valid_q || adv3;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  assign out_valid = s3_valid_q;
  assign out_prod  = s3_prod_q;
  assign out_tag   = s3_tag_q;

  assign s1_aspec_d = (in_a[14:7] == 8'hFF);
  assign s1_bspec_d = (in_b[14:7] == 8'hFF);
  assign s1_zero_d  = (in_a[14:7] == 8'h00) || (in_b[14:7] == 8'h00);

  assign s2_p_d    = {8'h00, s1_ma_q} * {8'h00, s1_mb_q};
  assign s2_esum_d = $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - 10'sd127;

`ifdef BF16_MUL_RNE_EN
  logic guard, sticky;
  always_comb begin
    guard  = s2_p_q[15] ? s2_p_q[7] : s2_p_q[6];
    sticky = s2_p_q[15] ? (|s2_p_q[6:0]) : (|s2_p_q[5:0]);
  end
`else
  logic unused_lo;
  assign unused_lo = ^s2_p_q[6:0];
`endif

  always_comb begin
    frac      = s2_p_q[13:7];
    e         = s2_esum_q;
    s3_prod_d = 16'h0000;
    if (s2_p_q[15]) begin
      frac = s2_p_q[14:8];
      e    = s2_esum_q + 10'sd1;
    end
`ifdef BF16_MUL_RNE_EN
    if (guard && (sticky || frac[0])) begin
      if (&frac) begin
        frac = 7'h00;
        e    = e + 10'sd1;
      end else begin
        frac = frac + 7'd1;
      end
    end
`endif
    if (s2_aspec_q)          s3_prod_d = s2_a_q;
    else if (s2_bspec_q)     s3_prod_d = s2_b_q;
    else if (s2_zero_q)      s3_prod_d = {s2_sign_q, 15'h0000};
    else if (e >= 10'sd255)  s3_prod_d = {s2_sign_q, 8'hFF, 7'h00};
    else if (e <= 10'sd0)    s3_prod_d = {s2_sign_q, 15'h0000};
    else                     s3_prod_d = {s2_sign_q, e[7:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_prod_q  <= 16'h0000;
      s3_tag_q   <= '0;
    end else begin
      if (adv1) s1_valid_q <= in_valid;
      if (adv2) s2_valid_q <= s1_valid_q;
      if (adv3) s3_valid_q <= s2_valid_q;
      if (adv3 && s2_valid_q) begin
        s3_prod_q <= s3_prod_d;
        s3_tag_q  <= s2_tag_q;
      end
    end
  end

  // Datapath registers need no reset: their valid bits gate every use.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_sign_q  <= in_a[15] ^ in_b[15];
      s1_ea_q    <= in_a[14:7];
      s1_eb_q    <= in_b[14:7];
      s1_ma_q    <= {1'b1, in_a[6:0]};
      s1_mb_q    <= {1'b1, in_b[6:0]};
      s1_aspec_q <= s1_aspec_d;
      s1_bspec_q <= s1_bspec_d;
      s1_zero_q  <= s1_zero_d;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s1_tag_q   <= in_tag;
    end
    if (adv2 && s1_valid_q) begin
      s2_sign_q  <= s1_sign_q;
      s2_p_q     <= s2_p_d;
      s2_esum_q  <= s2_esum_d;
      s2_aspec_q <= s1_aspec_q;
      s2_bspec_q <= s1_bspec_q;
      s2_zero_q  <= s1_zero_q;
      s2_a_q     <= s1_a_q;
      s2_b_q     <= s1_b_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// tb/tb_bf16_mul_pipe.sv - self-checking bench for bf16_mul_pipe
// Build with BF16_MUL_RNE_EN defined to check the round-to-nearest-even variant.
module tb_bf16_mul_pipe;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [15:0]      in_a, in_b, out_prod;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_cmp = 0;
  int n_bad = 0;
  logic [TAG_W+15:0] exp_q[$];
  logic [15:0]       exp_next;
  logic              last_in_fire;
  logic              stalled_prev;
  logic [15:0]       held_prod;
  logic [TAG_W-1:0]  held_tag;
  int                n_out_fire;

  always #5 clk = ~clk;

  bf16_mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  // Real-valued view: product = ma*mb * 2^(ea+eb-254-14); keep 7 fraction bits.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int   ea, eb, prod, sh, e, frac, rem, half;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 || eb == 0) return {s, 15'h0000};
    prod = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
    sh   = (prod >= 32768) ? 8 : 7;
    e    = ea + eb - 127 + (sh - 7);
    frac = (prod >> sh) % 128;
    rem  = prod % (1 << sh);
    half = 1 << (sh - 1);
`ifdef BF16_MUL_RNE_EN
    if (rem > half || (rem == half && (frac % 2) == 1)) frac = frac + 1;
    if (frac == 128) begin
      frac = 0;
      e    = e + 1;
    end
`else
    rem  = rem + half;
`endif
    if (e >= 255) return {s, 8'hFF, 7'h00};
    if (e <= 0) return {s, 15'h0000};
    return {s, e[7:0], frac[6:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 7) != 0) r[14:7] = 8'($urandom_range(100, 155));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // One clock: observe at negedge+1, then return at posedge+1 so the caller can drive.
  task automatic cycle();
    logic [TAG_W+15:0] ent;
    @(negedge clk);
    #1;
    if (stalled_prev) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_prod", out_prod, held_prod);
      check("hold_tag", out_tag, held_tag);
    end
    if (!rst && out_valid && out_ready) begin
      n_out_fire++;
      check("out_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        check("prod", out_prod, ent[15:0]);
        check("tag", out_tag, ent[TAG_W+15:16]);
      end
    end
    last_in_fire = !rst && in_valid && in_ready;
    if (last_in_fire) exp_q.push_back({in_tag, exp_next});
    if (rst) exp_q.delete();
    stalled_prev = !rst && out_valid && !out_ready;
    held_prod    = out_prod;
    held_tag     = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag, input logic [15:0] e);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    exp_next = e;
    do begin
      cycle();
      n++;
    end while (!last_in_fire && n < 100);
    check("send_accept", last_in_fire, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency_test();
    out_ready = 1'b1;
    send(16'h3FC0, 16'h4000, 4'd3, 16'h4040);
    check("lat_c1_valid", out_valid, 1'b0);
    cycle();
    check("lat_c2_valid", out_valid, 1'b0);
    cycle();
    check("lat_c3_valid", out_valid, 1'b1);
    check("lat_c3_prod", out_prod, 16'h4040);
    check("lat_c3_tag", out_tag, 4'd3);
    drain();
  endtask

  logic [15:0] dir_a[7], dir_b[7], dir_e[7];
  logic [15:0] sa[6], sb[6];
  int          sent, cyc;

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_tag       = '0;
    exp_next     = '0;
    stalled_prev = 1'b0;
    n_out_fire   = 0;
    cycle();
    cycle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_prod", out_prod, 16'h0000);
    check("rst_out_tag", out_tag, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    cycle();
    check("post_rst_in_ready", in_ready, 1'b1);

    latency_test();

    dir_a = '{16'hBF80, 16'h7F00, 16'h8000, 16'h7FC1, 16'h3FC1, 16'h3F81, 16'h0040};
    dir_b = '{16'h4040, 16'h4000, 16'h4040, 16'h3F80, 16'h3FC1, 16'h3F81, 16'h4000};
`ifdef BF16_MUL_RNE_EN
    dir_e = '{16'hC040, 16'h7F80, 16'h8000, 16'h7FC1, 16'h4012, 16'h3F82, 16'h0000};
`else
    dir_e = '{16'hC040, 16'h7F80, 16'h8000, 16'h7FC1, 16'h4011, 16'h3F82, 16'h0000};
`endif
    for (int i = 0; i < 7; i++) begin
      send(dir_a[i], dir_b[i], 4'(i), dir_e[i]);
      drain();
    end

    // Fill with the consumer stalled, then release and stream.
    for (int i = 0; i < 6; i++) begin
      sa[i] = rand_op();
      sb[i] = rand_op();
    end
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) send(sa[t], sb[t], 4'(t), ref_mul(sa[t], sb[t]));
    in_valid = 1'b1;
    in_a     = sa[3];
    in_b     = sb[3];
    in_tag   = 4'd3;
    exp_next = ref_mul(sa[3], sb[3]);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("full_no_accept", last_in_fire, 1'b0);
    end
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    check("full_head_prod", out_prod, ref_mul(sa[0], sb[0]));
    check("full_head_tag", out_tag, 4'd0);
    out_ready  = 1'b1;
    n_out_fire = 0;
    for (int t = 3; t < 6; t++) send(sa[t], sb[t], 4'(t), ref_mul(sa[t], sb[t]));
    for (int k = 0; k < 3; k++) cycle();
    check("stream_six_outputs", n_out_fire, 6);
    check("stream_empty", exp_q.size(), 0);

    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      in_tag    = 4'($urandom);
      exp_next  = ref_mul(in_a, in_b);
      cycle();
      if (last_in_fire) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("random_sent", sent, 200);
    drain();

    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) send(sa[t], sb[t], 4'(t), ref_mul(sa[t], sb[t]));
    check("pre_rst_full", in_ready, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_prod", out_prod, 16'h0000);
    latency_test();
    check("final_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bf16_mul_pipe.md
Name: bf16_mul_pipe

Overview:
- Three-stage pipelined bf16 multiplier with valid/ready handshakes on both sides.
- Sits directly upstream of bf16_adder in the MAC datapath; its product is the adder's `a` operand.
- Special-value, zero and truncation rules match the adder's, so the multiply-add chain is consistent.
- A sideband tag travels with each product so the consumer can match results to requests.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each operand pair.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair and tag present.
- in_ready  output  1  block accepts the pair this cycle.
- in_a  input  16  bf16 multiplicand.
- in_b  input  16  bf16 multiplier.
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  product present.
- out_ready  input  1  consumer accepts the product this cycle.
- out_prod  output  16  bf16 product.
- out_tag  output  TAG_W  tag of the product on out_prod.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high: when rst is high at a clk edge, s1_valid, s2_valid and s3_valid clear.
  - Outputs during and after reset: out_valid=0, out_prod=16'h0000, out_tag=0, in_ready=1.
  - Reset mid-operation discards all in-flight products; nothing drains.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid = s3_valid. out_prod and out_tag are held stable while out_valid && !out_ready.
- Stage advance (pipeline-stall with bubble collapsing):
  - adv3 = !s3_valid || out_ready
  - adv2 = !s2_valid || adv3
  - adv1 = !s1_valid || adv2
  - in_ready = adv1. It is combinational from out_ready; there is no combinational path from in_valid.
- Latency and throughput:
  - 3 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 product/cycle.
  - Capacity is 3 products. With out_ready held low, exactly 3 pairs are accepted, then in_ready=0.
  - Order is strictly preserved.
- S1 (unpack), registered:
  - sign = a[15]^b[15]; ea, eb; mantissas {1,frac}.
  - Flags: a_spec = (ea==8'hFF), b_spec = (eb==8'hFF), zero = (ea==0 || eb==0). Denormals are flushed to zero.
- S2 (multiply), registered:
  - 8x8 unsigned mantissa product, 16 bits.
  - Exponent sum: esum = ea + eb - 127, computed in 10-bit signed.
- S3 (normalise, pack), registered, evaluated in this priority:
  1. a_spec: out = a, passed unchanged.
  2. Else b_spec: out = b.
  3. Else zero: out = {sign, 15'h0}.
  4. Else normalise:
     - If p[15]: frac = p[14:8], e = esum+1.
     - Else: frac = p[13:7], e = esum.
     - Default rounding: truncate.
  5. After normalise/round:
     - e >= 255: saturate to {sign, 8'hFF, 7'h00}.
     - e <= 0: underflow to {sign, 15'h0}.

Optional Feature:
- Macro: BF16_MUL_RNE_EN.
- When defined, S3 rounds to nearest-even:
  - guard = first discarded bit; sticky = OR of the remaining discarded bits; lsb = frac[0].
  - Increment frac when guard && (sticky || lsb).
  - Mantissa carry-out increments e and zeroes frac.
  - Overflow/underflow checks apply after rounding.
- When not defined: truncation only, identical to the adder's convention. Latency is unchanged either way.

Test Plan:
- 0x3FC0 * 0x4000, tag 3, out_ready=1 → out_prod=0x4040, out_tag=3, out_valid exactly 3 cycles after the input transfer.
- 0xBF80 * 0x4040 → 0xC040. 0x7F00 * 0x4000 → 0x7F80 (saturated). 0x8000 * 0x4040 → 0x8000. 0x7FC1 * 0x3F80 → 0x7FC1 (special passes through).
- 0x3FC1 * 0x3FC1 → 0x4011 without BF16_MUL_RNE_EN; 0x4012 with it. 0x3F81 * 0x3F81 → 0x3F82 in both builds.
- out_ready=0, stream tags 0..5 back-to-back → in_ready drops after tags 0..2 are accepted and out_prod holds tag 0's result. Release out_ready → all 6 products emerge in tag order, one per cycle once streaming, none lost or duplicated.
- Random out_ready toggling with a 200-pair random stream → every output matches the reference model in order; no output change while out_valid && !out_ready.
- Assert rst for 1 cycle with 3 products in flight → next cycle out_valid=0 and in_ready=1; a subsequent 0x3FC0 * 0x4000 → 0x4040 after 3 cycles.
